// File: rtl/fifo_tx_ctrl_if.sv
// rtl/fifo_tx_ctrl_if.sv - push/pop/status bundle between register side, shifter side and the TX FIFO
interface fifo_tx_ctrl_if #(
    parameter int DATASIZE = 8,
    parameter int ADDRSIZE = 4
);
    logic [DATASIZE-1:0] wdata_i;
    logic                wr_en_i;
    logic                rd_en_i;
    logic                flush_i;
    logic                clr_err_i;
    logic [DATASIZE-1:0] rdata_o;
    logic                full_o;
    logic                empty_o;
    logic [ADDRSIZE:0]   count_o;
    logic                thresh_o;
    logic                overflow_o;
    logic                underflow_o;

    modport master (
        output wdata_i, wr_en_i, rd_en_i, flush_i, clr_err_i,
        input  rdata_o, full_o, empty_o, count_o, thresh_o, overflow_o, underflow_o
    );

    modport slave (
        input  wdata_i, wr_en_i, rd_en_i, flush_i, clr_err_i,
        output rdata_o, full_o, empty_o, count_o, thresh_o, overflow_o, underflow_o
    );
endinterface

// File: rtl/fifo_tx_ctrl.sv
// rtl/fifo_tx_ctrl.sv - single-clock first-word-fall-through transmit FIFO for the I2C byte shifter
module fifo_tx_ctrl #(
    parameter int DATASIZE  = 8,
    parameter int ADDRSIZE  = 4,
    parameter int TX_THRESH = 2
) (
    input  logic clk_i,
    input  logic rst_ni,
    fifo_tx_ctrl_if.slave bus
);
    localparam int DEPTH = 1 << ADDRSIZE;
    localparam logic [ADDRSIZE:0] THRESH = TX_THRESH[ADDRSIZE:0];

    logic [DATASIZE-1:0] r_mem [DEPTH];
    logic [ADDRSIZE:0]   r_wptr;
    logic [ADDRSIZE:0]   r_rptr;
    logic                r_overflow;
    logic                r_underflow;

    logic                w_empty;
    logic                w_full;
    logic [ADDRSIZE:0]   w_count;
    logic                w_pop;
    logic                w_push;
    logic                w_ovf_evt;
    logic                w_udf_evt;

    assign w_empty = (r_wptr == r_rptr);
    assign w_full  = (r_wptr[ADDRSIZE] != r_rptr[ADDRSIZE]) &&
                     (r_wptr[ADDRSIZE-1:0] == r_rptr[ADDRSIZE-1:0]);
    assign w_count = r_wptr - r_rptr;

    // Flush swallows both requests, so they can neither move pointers nor raise errors.
    assign w_pop     = bus.rd_en_i && !w_empty && !bus.flush_i;
    assign w_push    = bus.wr_en_i && (!w_full || w_pop) && !bus.flush_i;
    assign w_ovf_evt = bus.wr_en_i && w_full && !w_pop && !bus.flush_i;
    assign w_udf_evt = bus.rd_en_i && w_empty && !bus.flush_i;

    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_mem[r_wptr[ADDRSIZE-1:0]] <= bus.wdata_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else if (bus.flush_i) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
        end
    end

    // A fresh error in the same cycle as clr_err_i keeps the flag set.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (w_ovf_evt) begin
                r_overflow <= 1'b1;
            end else if (bus.clr_err_i) begin
                r_overflow <= 1'b0;
            end
            if (w_udf_evt) begin
                r_underflow <= 1'b1;
            end else if (bus.clr_err_i) begin
                r_underflow <= 1'b0;
            end
        end
    end

    assign bus.rdata_o     = r_mem[r_rptr[ADDRSIZE-1:0]];
    assign bus.empty_o     = w_empty;
    assign bus.full_o      = w_full;
    assign bus.count_o     = w_count;
    assign bus.thresh_o    = (w_count <= THRESH);
    assign bus.overflow_o  = r_overflow;
    assign bus.underflow_o = r_underflow;
endmodule

// File: doc/fifo_tx_ctrl.md
Name: fifo_tx_ctrl

Overview:
Single-clock transmit FIFO for the I2C datapath. It is the write-to-shifter counterpart of the RX FIFO: the register interface pushes bytes, and the I2C master byte shifter pops them.
- Contains its own storage, read/write pointers, occupancy count and status flags.
- First-word-fall-through: the head byte is presented combinationally on rdata_o.

Parameters:
DATASIZE, 8, data width in bits
ADDRSIZE, 4, address width; DEPTH = 1 << ADDRSIZE entries
TX_THRESH, 2, almost-empty threshold in entries (0 .. DEPTH)

Ports:
clk_i  input  1  single clock for both push and pop sides
rst_ni  input  1  reset, asynchronous, active-low
wdata_i  input  DATASIZE  byte to push
wr_en_i  input  1  push request (register side)
rd_en_i  input  1  pop request (shifter side)
flush_i  input  1  synchronous FIFO clear
clr_err_i  input  1  clears sticky error flags
rdata_o  output  DATASIZE  head-of-FIFO data (FWFT)
full_o  output  1  FIFO holds DEPTH entries
empty_o  output  1  FIFO holds 0 entries
count_o  output  ADDRSIZE+1  current occupancy, 0 .. DEPTH
thresh_o  output  1  count_o <= TX_THRESH (refill request)
overflow_o  output  1  sticky: push attempted while full and not accepted
underflow_o  output  1  sticky: pop attempted while empty

Behaviour:
- Reset (rst_ni low, async): wptr = rptr = 0, count_o = 0, empty_o = 1, full_o = 0, thresh_o = 1, overflow_o = underflow_o = 0. Memory contents are not reset.
- Pointers are ADDRSIZE+1 bits. The low ADDRSIZE bits index memory; the MSB is the wrap bit.
  - empty_o = (wptr == rptr).
  - full_o = (MSBs differ and low bits equal).
  - count_o = wptr - rptr, modulo 2^(ADDRSIZE+1).
- All status outputs are combinational from registered state, so they reflect an accepted push/pop on the cycle after the clock edge.
- rdata_o = mem[rptr low bits], combinational. It is valid whenever empty_o = 0 and don't-care when empty. It changes to the next entry the cycle after an accepted pop.
- Push accepted at a rising edge when wr_en_i = 1 and (full_o = 0, or rd_en_i = 1 with a pop accepted). Accepted push: mem[wptr] <= wdata_i, wptr + 1.
- Pop accepted when rd_en_i = 1 and empty_o = 0; rptr + 1.
- Simultaneous push + pop:
  - Not empty (including full): both accepted, count unchanged. When full, the write targets the slot being popped, and rdata_o in that cycle still shows the old head.
  - Empty: push accepted, pop rejected and underflow_o set. The pushed byte appears on rdata_o next cycle.
- Push while full without an accepted pop: data dropped, pointers unchanged, overflow_o <= 1.
- Pop while empty: pointers unchanged, underflow_o <= 1.
- Pointers wrap naturally at 2^(ADDRSIZE+1); no special case at the DEPTH boundary.
- flush_i = 1: wptr = rptr = 0 at the next edge. It has priority over wr_en_i/rd_en_i in the same cycle: no push, no pop, and no flags set by that cycle's requests. It does not clear sticky flags.
- clr_err_i = 1: overflow_o and underflow_o cleared at the next edge. A new error in the same cycle wins (flag stays/sets to 1).
- thresh_o = (count_o <= TX_THRESH). With TX_THRESH = DEPTH it is always 1.
- Reset mid-operation: all state returns to reset values immediately; queued data is lost.

Test Plan (DATASIZE=8, ADDRSIZE=4, DEPTH=16, TX_THRESH=2):
1. Reset, then push 0xA5 -> next cycle empty_o=0, count_o=1, rdata_o=0xA5, thresh_o=1. Pop -> empty_o=1, count_o=0.
2. Push 0x00..0x0F (16 writes) -> full_o=1, count_o=16, thresh_o=0. 17th push of 0xFF -> overflow_o=1, count_o=16. Pop 16 times -> rdata_o sequence 0x00..0x0F, then empty_o=1.
3. Full FIFO with head 0x00; wr_en_i=rd_en_i=1 with wdata_i=0x55 -> count_o stays 16, next head 0x01. After 15 more pops 0x55 is at the head.
4. Empty FIFO; wr_en_i=rd_en_i=1 with 0x3C -> underflow_o=1, count_o=1, rdata_o=0x3C. Then clr_err_i=1 -> underflow_o=0.
5. 40 interleaved pushes/pops across two pointer wraps, occupancy kept between 1 and 5 -> FIFO order preserved, thresh_o toggles exactly when count_o crosses 2/3.
6. Count 7, assert flush_i together with wr_en_i -> next cycle count_o=0, empty_o=0->1, no overflow. Assert rst_ni low mid-burst -> all outputs at reset values asynchronously.
